// File: rtl/fft_frame_ctrl.sv
// Frame sequencer around an in-place FFT: windows and bit-reverse loads N samples,
// kicks the core, then streams the N results out through a 2-entry skid buffer.
module fft_frame_ctrl #(
  parameter int width = 16,
  parameter int logn  = 11
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  input  logic [width-1:0]     in_sample,
  output logic                 in_ready,
  output logic [logn-1:0]      hann_idx,
  input  logic [width-1:0]     hann_coef,
  output logic                 load_we,
  output logic [logn-1:0]      load_adr,
  output logic [2*width-1:0]   load_wd,
  output logic                 fft_start,
  input  logic                 fft_done,
  output logic [logn-1:0]      out_adr,
  input  logic [2*width-1:0]   out_rd,
  output logic                 out_valid,
  output logic [2*width-1:0]   out_data,
  output logic                 out_last,
  input  logic                 out_ready,
  output logic                 busy
);

  localparam logic [logn-1:0] LAST = '1;

  typedef enum logic [1:0] {LOAD, START, COMPUTE, UNLOAD} state_t;

  state_t             state_q;
  logic               in_ready_q, fft_start_q, busy_q;
  logic [logn-1:0]    smp_cnt_q, wr_adr_q, rd_cnt_q;
  logic [width-1:0]   smp_q;
  logic               wr_vld_q, wr_last_q;
  logic               rd_done_q, rd_pend_q, rd_pend_last_q;
  logic [2*width-1:0] sk_dat_q [2];
  logic               sk_last_q [2];
  logic               sk_wp_q, sk_rp_q;
  logic [1:0]         sk_cnt_q;

  logic               accept, pop, push, rd_issue;
  logic [2:0]         occ;
  logic signed [2*width:0] smp_x, coef_x, prod;
  logic               unused_prod;

  function automatic logic [logn-1:0] bitrev(input logic [logn-1:0] a);
    logic [logn-1:0] r;
    for (int i = 0; i < logn; i++) r[i] = a[logn-1-i];
    return r;
  endfunction

  assign accept   = in_valid && in_ready_q;
  assign pop      = (sk_cnt_q != 2'd0) && out_ready;
  assign push     = rd_pend_q;
  // Reads in flight plus buffered entries must never exceed the two skid slots.
  assign occ      = {1'b0, sk_cnt_q} + {2'b00, rd_pend_q} - {2'b00, pop};
  assign rd_issue = (state_q == UNLOAD) && !rd_done_q && (occ <= 3'd1);

  // Coefficient is unsigned Q0.width, so it is zero-extended before the signed multiply.
  assign smp_x       = {{(width+1){smp_q[width-1]}}, smp_q};
  assign coef_x      = {{(width+1){1'b0}}, hann_coef};
  assign prod        = smp_x * coef_x;
  assign unused_prod = ^{prod[2*width], prod[width-1:0]};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= LOAD;
      in_ready_q     <= 1'b0;
      fft_start_q    <= 1'b0;
      busy_q         <= 1'b0;
      smp_cnt_q      <= '0;
      smp_q          <= '0;
      wr_vld_q       <= 1'b0;
      wr_last_q      <= 1'b0;
      wr_adr_q       <= '0;
      rd_cnt_q       <= '0;
      rd_done_q      <= 1'b0;
      rd_pend_q      <= 1'b0;
      rd_pend_last_q <= 1'b0;
    end else begin
      wr_vld_q       <= 1'b0;
      fft_start_q    <= 1'b0;
      rd_pend_q      <= rd_issue;
      rd_pend_last_q <= (rd_cnt_q == LAST);
      case (state_q)
        LOAD: begin
          if (accept) begin
            smp_q     <= in_sample;
            wr_vld_q  <= 1'b1;
            wr_adr_q  <= bitrev(smp_cnt_q);
            wr_last_q <= (smp_cnt_q == LAST);
            if (smp_cnt_q == LAST) begin
              smp_cnt_q  <= '0;
              in_ready_q <= 1'b0;
            end else begin
              smp_cnt_q <= smp_cnt_q + 1'b1;
            end
          end
          if (wr_vld_q && wr_last_q) begin
            state_q     <= START;
            fft_start_q <= 1'b1;
            busy_q      <= 1'b1;
          end else if (!in_ready_q) begin
            in_ready_q <= 1'b1;
          end
        end
        START: state_q <= COMPUTE;
        COMPUTE: if (fft_done) state_q <= UNLOAD;
        UNLOAD: begin
          if (rd_issue) begin
            if (rd_cnt_q == LAST) rd_done_q <= 1'b1;
            else                  rd_cnt_q  <= rd_cnt_q + 1'b1;
          end
          if (pop && out_last) begin
            state_q    <= LOAD;
            busy_q     <= 1'b0;
            in_ready_q <= 1'b1;
            rd_cnt_q   <= '0;
            rd_done_q  <= 1'b0;
          end
        end
        default: state_q <= LOAD;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 2; i++) begin
        sk_dat_q[i]  <= '0;
        sk_last_q[i] <= 1'b0;
      end
      sk_wp_q  <= 1'b0;
      sk_rp_q  <= 1'b0;
      sk_cnt_q <= 2'd0;
    end else begin
      if (push) begin
        sk_dat_q[sk_wp_q]  <= out_rd;
        sk_last_q[sk_wp_q] <= rd_pend_last_q;
        sk_wp_q            <= ~sk_wp_q;
      end
      if (pop) sk_rp_q <= ~sk_rp_q;
      sk_cnt_q <= sk_cnt_q + {1'b0, push} - {1'b0, pop};
    end
  end

  assign in_ready  = in_ready_q;
  assign hann_idx  = smp_cnt_q;
  assign load_we   = wr_vld_q;
  assign load_adr  = wr_adr_q;
  assign load_wd   = {prod[2*width-1:width], {width{1'b0}}};
  assign fft_start = fft_start_q;
  assign busy      = busy_q;
  assign out_adr   = rd_cnt_q;
  assign out_valid = (sk_cnt_q != 2'd0);
  assign out_data  = sk_dat_q[sk_rp_q];
  assign out_last  = out_valid && sk_last_q[sk_rp_q];

endmodule

// File: tb/tb_fft_frame_ctrl.sv
// Directed bench for fft_frame_ctrl with window-LUT and result-RAM models.
module tb_fft_frame_ctrl;

  logic        clk, reset;
  logic        in_valid, in_ready;
  logic [15:0] in_sample, hann_coef;
  logic [10:0] hann_idx, load_adr, out_adr;
  logic        load_we, fft_start, fft_done, out_valid, out_last, out_ready, busy;
  logic [31:0] load_wd, out_rd, out_data;

  int checks = 0;
  int errors = 0;
  int mode = 0;
  int writes, dups, load_iters, unload_iters, first_vld, starts;
  logic [10:0] adr1, adr2;
  logic [31:0] wd0, wd3;
  bit seen [2048];

  fft_frame_ctrl #(.width(16), .logn(11)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_sample(in_sample), .in_ready(in_ready),
    .hann_idx(hann_idx), .hann_coef(hann_coef),
    .load_we(load_we), .load_adr(load_adr), .load_wd(load_wd),
    .fft_start(fft_start), .fft_done(fft_done),
    .out_adr(out_adr), .out_rd(out_rd),
    .out_valid(out_valid), .out_data(out_data), .out_last(out_last), .out_ready(out_ready),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] smp_fn(input int n);
    if (mode == 0) return 16'h0100;
    if (n == 0) return 16'h8000;
    return 16'(n * 97 - 20000);
  endfunction

  function automatic logic [15:0] coef_fn(input int idx);
    if (mode == 0) return 16'h8000;
    if (idx == 0) return 16'hFFFF;
    return 16'(idx * 31 + 7);
  endfunction

  function automatic logic [31:0] ram_fn(input int a);
    logic [10:0] x;
    x = 11'(a);
    return {5'h00, x, 5'h1f, ~x};
  endfunction

  function automatic logic [10:0] brev(input int n);
    logic [10:0] a, r;
    a = 11'(n);
    for (int i = 0; i < 11; i++) r[i] = a[10-i];
    return r;
  endfunction

  function automatic logic [31:0] exp_wd(input int n);
    logic signed [15:0] s;
    logic [15:0] c;
    longint p;
    logic [63:0] q;
    s = smp_fn(n);
    c = coef_fn(n);
    p = longint'(s) * longint'(c);
    q = 64'(p >>> 16);
    return {q[15:0], 16'h0000};
  endfunction

  // Window LUT and result RAM: both answer one cycle after the address.
  always @(posedge clk) begin
    hann_coef <= coef_fn(int'(hann_idx));
    out_rd    <= ram_fn(int'(out_adr));
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_in_ready"},  64'(in_ready), 64'(0));
    chk({tag, "_load_we"},   64'(load_we), 64'(0));
    chk({tag, "_fft_start"}, 64'(fft_start), 64'(0));
    chk({tag, "_out_valid"}, 64'(out_valid), 64'(0));
    chk({tag, "_out_last"},  64'(out_last), 64'(0));
    chk({tag, "_busy"},      64'(busy), 64'(0));
    chk({tag, "_hann_idx"},  64'(hann_idx), 64'(0));
    chk({tag, "_load_adr"},  64'(load_adr), 64'(0));
    chk({tag, "_load_wd"},   64'(load_wd), 64'(0));
    chk({tag, "_out_adr"},   64'(out_adr), 64'(0));
    chk({tag, "_out_data"},  64'(out_data), 64'(0));
  endtask

  task automatic run_load(input bit toggle, input int stop_n);
    int n, iters;
    bit acc;
    n = 0; iters = 0; writes = 0; dups = 0;
    foreach (seen[i]) seen[i] = 1'b0;
    while (n < stop_n && iters < 10000) begin
      in_valid  = toggle ? (iters % 2 == 0) : 1'b1;
      in_sample = smp_fn(n);
      acc = in_valid && in_ready;
      if (acc) chk("hann_idx", 64'(hann_idx), 64'(n));
      step();
      iters++;
      if (acc) begin
        chk("load_we", 64'(load_we), 64'(1));
        chk("load_adr", 64'(load_adr), 64'(brev(n)));
        chk("load_wd", 64'(load_wd), 64'(exp_wd(n)));
        if (seen[load_adr]) dups++;
        seen[load_adr] = 1'b1;
        writes++;
        if (n == 0) wd0 = load_wd;
        if (n == 1) adr1 = load_adr;
        if (n == 2) adr2 = load_adr;
        if (n == 3) wd3 = load_wd;
        n++;
      end else begin
        chk("load_we_idle", 64'(load_we), 64'(0));
      end
    end
    in_valid = 1'b0;
    load_iters = iters;
    chk("load_count", 64'(n), 64'(stop_n));
  endtask

  task automatic run_unload(input bit rnd, input int stop_n);
    int idx, iters;
    bit hs, stalled;
    logic [33:0] held;
    idx = 0; iters = 0; stalled = 1'b0; held = '0;
    first_vld = -1;
    while (idx < stop_n && iters < 20000) begin
      out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (stalled) chk("out_hold", 64'({out_valid, out_last, out_data}), 64'(held));
      if (out_valid) begin
        if (first_vld < 0) first_vld = iters;
        chk("out_data", 64'(out_data), 64'(ram_fn(idx)));
        chk("out_last", 64'(out_last), 64'(idx == 2047));
      end
      hs      = out_valid && out_ready;
      stalled = out_valid && !out_ready;
      held    = {out_valid, out_last, out_data};
      step();
      iters++;
      if (hs) idx++;
    end
    out_ready = 1'b0;
    unload_iters = iters;
    chk("unload_count", 64'(idx), 64'(stop_n));
  endtask

  task automatic start_and_compute();
    step();
    chk("fft_start", 64'(fft_start), 64'(1));
    chk("busy_start", 64'(busy), 64'(1));
    starts = 0;
    repeat (6) begin
      step();
      if (fft_start) starts++;
    end
    chk("fft_start_once", 64'(starts), 64'(0));
    chk("compute_no_out", 64'(out_valid), 64'(0));
    fft_done = 1'b1;
    step();
    fft_done = 1'b0;
    chk("unload_busy", 64'(busy), 64'(1));
    chk("unload_first_cycle", 64'(out_valid), 64'(0));
  endtask

  task automatic chk_back_in_load(input string tag);
    chk({tag, "_in_ready"}, 64'(in_ready), 64'(1));
    chk({tag, "_busy"}, 64'(busy), 64'(0));
    chk({tag, "_hann_idx"}, 64'(hann_idx), 64'(0));
    chk({tag, "_out_valid"}, 64'(out_valid), 64'(0));
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_sample = '0; fft_done = 1'b0; out_ready = 1'b0;
    #2;
    chk_zero("rst0");
    @(posedge clk);
    #1;
    reset = 1'b0;
    chk("in_ready_pre", 64'(in_ready), 64'(0));
    step();
    chk("in_ready_rise", 64'(in_ready), 64'(1));

    fft_done = 1'b1;
    step();
    fft_done = 1'b0;
    chk("done_in_load_busy", 64'(busy), 64'(0));
    chk("done_in_load_ready", 64'(in_ready), 64'(1));
    chk("done_in_load_start", 64'(fft_start), 64'(0));

    // Frame 1: constant samples, back-to-back, downstream always ready.
    mode = 0;
    run_load(1'b0, 2048);
    chk("load_cycles", 64'(load_iters), 64'(2048));
    chk("adr_n1", 64'(adr1), 64'(11'h400));
    chk("adr_n2", 64'(adr2), 64'(11'h200));
    chk("wd_const", 64'(wd0), 64'(32'h0080_0000));
    chk("in_ready_drop", 64'(in_ready), 64'(0));
    start_and_compute();
    run_unload(1'b0, 2048);
    chk("first_out_latency", 64'(first_vld), 64'(2));
    chk("unload_cycles", 64'(unload_iters), 64'(2050));
    chk_back_in_load("f1_end");

    // Frame 2: gapped input, signed data, random downstream stalls.
    mode = 1;
    run_load(1'b1, 2048);
    chk("gap_writes", 64'(writes), 64'(2048));
    chk("gap_dups", 64'(dups), 64'(0));
    chk("wd_neg_full", 64'(wd0), 64'(32'h8000_0000));
    chk("wd_n3", 64'(wd3), 64'(32'hFFE1_0000));
    start_and_compute();
    run_unload(1'b1, 2048);
    chk_back_in_load("f2_end");

    // Reset in the middle of loading discards the partial frame.
    run_load(1'b0, 1000);
    #2;
    reset = 1'b1;
    #1;
    chk_zero("rst_load");
    @(posedge clk);
    #1;
    reset = 1'b0;
    chk("rst_load_pre", 64'(in_ready), 64'(0));
    step();
    chk("rst_load_rise", 64'(in_ready), 64'(1));
    run_load(1'b0, 2048);
    start_and_compute();

    // Reset in the middle of unloading.
    run_unload(1'b1, 700);
    #2;
    reset = 1'b1;
    #1;
    chk_zero("rst_unload");
    @(posedge clk);
    #1;
    reset = 1'b0;
    step();
    chk("rst_unload_rise", 64'(in_ready), 64'(1));
    run_load(1'b0, 16);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
